user_proj_mul_wide: RTL and testbench

Wishbone-slave multiplier for the user project area. It replaces the fixed 32-bit, bus-stalling multiplier wrapper with a WIDTH-parametrised, non-blocking engine: software writes operands, starts an operation through CTRL, then polls STATUS or waits for an interrupt. It supports unsigned and signed (two's-complement) modes and returns a full 2·WIDTH-bit product. It sits on the management SoC's Wishbone bus; LA and I/O pads are not used.

---
 rtl/mul_pkg.sv | 37 +++
 rtl/user_proj_mul_wide_seq.sv | 69 ++++++
 rtl/user_proj_mul_wide.sv | 142 ++++++++++++++
 tb/tb_user_proj_mul_wide.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared constants for the Wishbone multiplier: register map, CTRL/STATUS bit
// positions, sequencer state encoding and the unmapped-read filler.
package mul_pkg;

    localparam logic [7:0] ADR_MP     = 8'h00;
    localparam logic [7:0] ADR_MC     = 8'h04;
    localparam logic [7:0] ADR_CTRL   = 8'h08;
    localparam logic [7:0] ADR_STATUS = 8'h0C;
    localparam logic [7:0] ADR_P_LO   = 8'h10;
    localparam logic [7:0] ADR_P_HI   = 8'h14;

    localparam int CTRL_START = 0;
    localparam int CTRL_SGN   = 1;
    localparam int CTRL_IE    = 2;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    localparam logic [31:0] FILLER = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mul_state_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/user_proj_mul_wide_seq.sv
// Sign-magnitude shift-add multiplier: latches |a| and |b|, accumulates one
// multiplier bit per cycle MSB first, then applies the sign in a FIX cycle.
module mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done_pulse,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CNT_W = $clog2(WIDTH);

    mul_state_e         state;
    logic [WIDTH-1:0]   mpl;
    logic [WIDTH-1:0]   mcd;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               neg;

    // -2^(WIDTH-1) wraps back onto itself, which read unsigned is its magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? (~x) + WIDTH'(1) : x;
    endfunction

    // NOTE: state uses non-blocking assignments so every branch reads the
    // pre-edge values of acc/cnt regardless of statement order.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            mpl   <= '0;
            mcd   <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= CALC;
                    mpl   <= mag(a, sgn);
                    mcd   <= mag(b, sgn);
                    neg   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc   <= '0;
                    cnt   <= CNT_W'(WIDTH - 1);
                end
                CALC: begin
                    acc <= {acc[2*WIDTH-2:0], 1'b0}
                         + {{WIDTH{1'b0}}, (mpl[cnt] ? mcd : {WIDTH{1'b0}})};
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                FIX:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign done_pulse = (state == FIX);
    assign p          = neg ? (~acc) + (2*WIDTH)'(1) : acc;

endmodule

// File: rtl/user_proj_mul_wide.sv
// Wishbone slave front end of the multiplier: register file, START/ERR/DONE
// bookkeeping, 64-bit product register and the completion interrupt.
module user_proj_mul_wide
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
`ifdef USE_POWER_PINS
    inout  wire          vccd1,
    inout  wire          vssd1,
`endif
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_adr_i,
    input  logic [31:0]  wbs_dat_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    output logic [2:0]   irq
);

    logic [WIDTH-1:0]   mp;
    logic [WIDTH-1:0]   mc;
    logic               ctrl_sgn;
    logic               ctrl_ie;
    logic               st_done;
    logic               st_err;
    logic               op_sgn;
    logic [63:0]        p_reg;
    logic               irq_done;

    logic               busy;
    logic               done_pulse;
    logic [2*WIDTH-1:0] p;
    logic [63:0]        p_ext;
    logic [31:0]        rdata;

    logic [7:0] adr;
    logic       bus_sel, wr_req, ctrl_wr, status_wr, start_req, start_go;
    logic       unused_adr;

    assign adr        = wbs_adr_i[7:0];
    assign unused_adr = &{1'b0, wbs_adr_i[31:8]};

    assign bus_sel   = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign wr_req    = bus_sel & wbs_we_i;
    assign ctrl_wr   = wr_req & (adr == ADR_CTRL)   & wbs_sel_i[0];
    assign status_wr = wr_req & (adr == ADR_STATUS) & wbs_sel_i[0];
    assign start_req = ctrl_wr & wbs_dat_i[CTRL_START];
    assign start_go  = start_req & ~busy;

    mul_seq #(.WIDTH(WIDTH)) u_seq (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .start      (start_go),
        .sgn        (wbs_dat_i[CTRL_SGN]),
        .a          (mp),
        .b          (mc),
        .busy       (busy),
        .done_pulse (done_pulse),
        .p          (p)
    );

    always_comb begin
        if (op_sgn) p_ext = 64'($signed(p));
        else        p_ext = 64'(p);
    end

    // NOTE: default assigned first so every path drives rdata; no latch.
    always_comb begin
        rdata = FILLER;
        case (adr)
            ADR_MP:   rdata = 32'(mp);
            ADR_MC:   rdata = 32'(mc);
            ADR_CTRL: begin
                rdata = '0;
                rdata[CTRL_SGN] = ctrl_sgn;
                rdata[CTRL_IE]  = ctrl_ie;
            end
            ADR_STATUS: begin
                rdata = '0;
                rdata[ST_BUSY] = busy;
                rdata[ST_DONE] = st_done;
                rdata[ST_ERR]  = st_err;
            end
            ADR_P_LO: rdata = p_reg[31:0];
            ADR_P_HI: rdata = p_reg[63:32];
            default:  rdata = FILLER;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            mp        <= '0;
            mc        <= '0;
            ctrl_sgn  <= 1'b0;
            ctrl_ie   <= 1'b0;
            st_done   <= 1'b0;
            st_err    <= 1'b0;
            op_sgn    <= 1'b0;
            p_reg     <= '0;
            irq_done  <= 1'b0;
        end else begin
            wbs_ack_o <= bus_sel;
            if (bus_sel && !wbs_we_i) wbs_dat_o <= rdata;

            if (wr_req && adr == ADR_MP)
                mp <= WIDTH'(byte_merge(32'(mp), wbs_dat_i, wbs_sel_i));
            if (wr_req && adr == ADR_MC)
                mc <= WIDTH'(byte_merge(32'(mc), wbs_dat_i, wbs_sel_i));

            if (ctrl_wr) begin
                ctrl_sgn <= wbs_dat_i[CTRL_SGN];
                ctrl_ie  <= wbs_dat_i[CTRL_IE];
            end
            if (start_go) op_sgn <= wbs_dat_i[CTRL_SGN];

            if (start_req && busy)
                st_err <= 1'b1;
            else if (status_wr && wbs_dat_i[ST_ERR])
                st_err <= 1'b0;

            // Completion beats a same-cycle write-1-to-clear of DONE.
            if (done_pulse) begin
                st_done <= 1'b1;
                p_reg   <= p_ext;
            end else if (start_go || (status_wr && wbs_dat_i[ST_DONE])) begin
                st_done <= 1'b0;
            end

            irq_done <= st_done & ctrl_ie;
        end
    end

    assign irq = {2'b00, irq_done};

endmodule

// File: tb/tb_user_proj_mul_wide.sv
// Scoreboard bench: a 32-bit and an 8-bit instance share one bus; reads push
// expected data into per-instance queues that a negedge monitor drains on ack.
module tb_user_proj_mul_wide;

    localparam logic [7:0] A_MP = 8'h00, A_MC = 8'h04, A_CTRL = 8'h08;
    localparam logic [7:0] A_STATUS = 8'h0C, A_P_LO = 8'h10, A_P_HI = 8'h14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb32 = 1'b0, stb8 = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack32, ack8;
    logic [31:0] rd32, rd8;
    logic [2:0]  irq32, irq8;

    int n_chk = 0;
    int n_err = 0;
    int ncyc  = 0;

    typedef struct {
        bit          chk;
        logic [31:0] exp;
        string       nm;
    } exp_t;

    exp_t        q32[$];
    exp_t        q8[$];
    logic        err_sh[2];
    logic [63:0] p_sh[2];

    always #5 clk = ~clk;
    always @(posedge clk) ncyc <= ncyc + 1;

    user_proj_mul_wide #(.WIDTH(32)) u32 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb32), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack32), .wbs_dat_o(rd32), .irq(irq32)
    );

    user_proj_mul_wide #(.WIDTH(8)) u8 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb8), .wbs_cyc_i(cyc),
        .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
        .wbs_ack_o(ack8), .wbs_dat_o(rd8), .irq(irq8)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int dw(input int d);
        return (d == 0) ? 32 : 8;
    endfunction

    function automatic logic [31:0] wmask(input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return m[31:0];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    // Reference product: plain integer arithmetic on the w-bit operands.
    function automatic logic [63:0] ref_mul(input int w, input bit sg,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m;
        longint      sa, sb;
        logic [63:0] ua, ub;
        m  = wmask(w);
        ua = {32'd0, a & m};
        ub = {32'd0, b & m};
        if (!sg) return ua * ub;
        sa = longint'(ua);
        sb = longint'(ub);
        if (a[w-1]) sa = sa - (64'sd1 <<< w);
        if (b[w-1]) sb = sb - (64'sd1 <<< w);
        return 64'(sa * sb);
    endfunction

    task automatic pop_cmp(input int d);
        exp_t e;
        if ((d == 0 && q32.size() == 0) || (d == 1 && q8.size() == 0)) begin
            check($sformatf("spurious_ack_d%0d", d), 64'd1, 64'd0);
        end else begin
            e = (d == 0) ? q32.pop_front() : q8.pop_front();
            if (e.chk) check(e.nm, 64'((d == 0) ? rd32 : rd8), 64'(e.exp));
        end
    endtask

    always @(negedge clk) begin
        if (ack32 === 1'b1) pop_cmp(0);
        if (ack8 === 1'b1)  pop_cmp(1);
    end

    // Entered just after a posedge; commits on the next edge, returns 1 edge later.
    task automatic bus(input int d, input bit wr, input logic [7:0] a, input logic [31:0] dat,
                       input logic [3:0] s, input bit chk, input logic [31:0] exp,
                       input string nm);
        exp_t e;
        e.chk = chk; e.exp = exp; e.nm = $sformatf("%s_d%0d", nm, d);
        if (d == 0) q32.push_back(e); else q8.push_back(e);
        we = wr; adr = {24'd0, a}; wdat = dat; sel = s; cyc = 1'b1;
        if (d == 0) stb32 = 1'b1; else stb8 = 1'b1;
        @(posedge clk); #1;
        check({e.nm, "_ack"}, 64'((d == 0) ? ack32 : ack8), 64'd1);
        stb32 = 1'b0; stb8 = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check({e.nm, "_ack_drop"}, 64'((d == 0) ? ack32 : ack8), 64'd0);
    endtask

    task automatic wr(input int d, input logic [7:0] a, input logic [31:0] dat);
        bus(d, 1'b1, a, dat, 4'hF, 1'b0, '0, "wr");
    endtask

    task automatic rd(input int d, input logic [7:0] a, input logic [31:0] exp, input string nm);
        bus(d, 1'b0, a, '0, 4'hF, 1'b1, exp, nm);
    endtask

    task automatic wait_until(input int target);
        for (int k = 0; k < 200 && ncyc < target; k++) begin
            @(posedge clk); #1;
        end
    endtask

    // One operation; STATUS polled each access with BUSY/DONE expected from the
    // edge count since the START commit, then product and CTRL read back.
    task automatic run_op(input int d, input bit sg, input bit ie,
                          input logic [31:0] a, input logic [31:0] b, input int phase);
        int          w, e0;
        logic [63:0] pe;
        bit          dn;
        w = dw(d);
        wr(d, A_MP, a);
        wr(d, A_MC, b);
        rd(d, A_MP, a & wmask(w), "mp_readback");
        e0 = ncyc + 1;
        bus(d, 1'b1, A_CTRL, {29'd0, ie, sg, 1'b1}, 4'h1, 1'b0, '0, "start");
        pe = ref_mul(w, sg, a, b);
        repeat (phase) begin @(posedge clk); #1; end
        while (ncyc + 1 <= e0 + w + 4) begin
            dn = (ncyc >= e0 + w + 1);
            rd(d, A_STATUS, {29'd0, err_sh[d], dn, !dn}, "status_poll");
        end
        rd(d, A_P_LO, pe[31:0], "p_lo");
        rd(d, A_P_HI, pe[63:32], "p_hi");
        rd(d, A_CTRL, {29'd0, ie, sg, 1'b0}, "ctrl_readback");
        p_sh[d] = pe;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1);
    end

    initial begin
        int e0, rise;
        err_sh[0] = 1'b0; err_sh[1] = 1'b0;
        p_sh[0] = '0; p_sh[1] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ack32", 64'(ack32), 64'd0);
        check("reset_dat32", 64'(rd32), 64'd0);
        check("reset_irq8", 64'(irq8), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            rd(d, A_STATUS, 32'd0, "reset_status");
            rd(d, A_P_HI, 32'd0, "reset_p_hi");
        end

        // Full-scale unsigned, both poll phases to pin DONE to E0+WIDTH+1.
        run_op(0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run_op(0, 1'b1, 1'b0, 32'hFFFF_FFFD, 32'h0000_0007, 0);
        run_op(0, 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1);

        // START while busy, operand write while busy, P read while busy, irq timing.
        wr(0, A_MP, 32'd5);
        wr(0, A_MC, 32'd6);
        e0 = ncyc + 1;
        bus(0, 1'b1, A_CTRL, 32'h5, 4'h1, 1'b0, '0, "start_ie");
        rd(0, A_P_LO, p_sh[0][31:0], "p_lo_while_busy");
        wait_until(e0 + 9);
        bus(0, 1'b1, A_CTRL, 32'h5, 4'h1, 1'b0, '0, "restart_busy");
        err_sh[0] = 1'b1;
        wr(0, A_MP, 32'h99);
        rise = -1;
        for (int k = 0; k < 64 && rise < 0; k++) begin
            if (irq32[0] === 1'b1) rise = ncyc;
            else begin @(posedge clk); #1; end
        end
        check("irq_rise_latency", 64'(rise - e0), 64'(32 + 2));
        rd(0, A_STATUS, 32'h6, "status_err_done");
        rd(0, A_P_LO, 32'd30, "p_lo_after_restart");
        rd(0, A_MP, 32'h99, "mp_written_busy");
        bus(0, 1'b1, A_STATUS, 32'h6, 4'h1, 1'b0, '0, "w1c");
        err_sh[0] = 1'b0;
        check("irq_cleared", 64'(irq32), 64'd0);
        rd(0, A_STATUS, 32'h0, "status_cleared");

        // DONE set wins over a same-edge write-1-to-clear.
        wr(1, A_MP, 32'd3);
        wr(1, A_MC, 32'd5);
        e0 = ncyc + 1;
        bus(1, 1'b1, A_CTRL, 32'h1, 4'h1, 1'b0, '0, "start8");
        wait_until(e0 + 8);
        bus(1, 1'b1, A_STATUS, 32'h2, 4'h1, 1'b0, '0, "w1c_at_fix");
        rd(1, A_STATUS, 32'h2, "done_set_wins");
        rd(1, A_P_LO, 32'd15, "p_lo_3x5");
        bus(1, 1'b1, A_STATUS, 32'h2, 4'h1, 1'b0, '0, "w1c_done");
        rd(1, A_STATUS, 32'h0, "done_cleared");

        // 8-bit corners, both poll phases.
        run_op(1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_00FF, 0);
        run_op(1, 1'b1, 1'b0, 32'h0000_00FF, 32'h0000_00FF, 1);
        run_op(1, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0080, 0);
        run_op(1, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0001, 1);

        // Unmapped offset and byte-masked write.
        for (int d = 0; d < 2; d++) begin
            rd(d, 8'h20, 32'hDEAD_BEEF, "unmapped_read");
            wr(d, 8'h20, 32'h1234_5678);
            wr(d, A_MP, 32'h1122_3344);
            bus(d, 1'b1, A_MP, 32'h0000_AB00, 4'b0010, 1'b0, '0, "byte_wr");
            rd(d, A_MP, merge(32'h1122_3344, 32'h0000_AB00, 4'b0010) & wmask(dw(d)), "mp_byte");
        end

        // Randomised operations on both widths.
        for (int i = 0; i < 12; i++) begin
            run_op(i % 2, 1'($urandom_range(1)), 1'b0, $urandom, $urandom,
                   int'($urandom_range(1)));
        end

        // Reset mid-operation: 8-bit instance left with DONE/irq set, 32-bit busy.
        run_op(1, 1'b0, 1'b1, 32'd7, 32'd9, 0);
        check("irq8_set_before_reset", 64'(irq8), 64'd1);
        wr(0, A_MP, 32'h1234);
        wr(0, A_MC, 32'h5678);
        bus(0, 1'b1, A_CTRL, 32'h7, 4'h1, 1'b0, '0, "start_pre_reset");
        repeat (9) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_async_irq8", 64'(irq8), 64'd0);
        check("rst_async_ack32", 64'(ack32), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        err_sh[0] = 1'b0; err_sh[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rd(d, A_MP, 32'd0, "post_rst_mp");
            rd(d, A_MC, 32'd0, "post_rst_mc");
            rd(d, A_CTRL, 32'd0, "post_rst_ctrl");
            rd(d, A_STATUS, 32'd0, "post_rst_status");
            rd(d, A_P_LO, 32'd0, "post_rst_p_lo");
            rd(d, A_P_HI, 32'd0, "post_rst_p_hi");
        end
        check("post_rst_irq32", 64'(irq32), 64'd0);
        run_op(0, 1'b0, 1'b0, 32'd3, 32'd4, 0);

        repeat (3) @(posedge clk);
        #1;
        check("q32_leftover", 64'(q32.size()), 64'd0);
        check("q8_leftover", 64'(q8.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
